a51_stream_decryptor: RTL and testbench

- Decrypts an encrypted pixel byte stream by XORing it with A5/1 keystream.
- Holds all three A5/1 LFSRs (X 19-bit, Y 22-bit, Z 23-bit) with majority clocking.
- Sequences key load, frame load and mixing, then produces eight keystream bits per byte.
- Sits at the receive end of the image path, opposite the encrypting side; given the same key and frame it regenerates the identical keystream.

---
 rtl/a51_stream_decryptor.sv | 147 ++++++++++++++
 tb/tb_a51_stream_decryptor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/a51_stream_decryptor.sv
// A5/1 stream decryptor: regenerates the keystream from key/frame and XORs it onto incoming bytes.
// Optional keystream debug tap enabled by defining A51_KEYSTREAM_TAP_EN.
//
// state        | meaning
// S_IDLE       | registers hold, waiting for start
// S_LOAD_KEY   | 64 cycles, all registers shift, key bit injected
// S_LOAD_FRAME | 22 cycles, all registers shift, frame bit injected
// S_MIX        | MIX_CYCLES majority-clocked cycles, keystream discarded
// S_WAIT       | in_ready high, waiting for an encrypted byte
// S_GEN        | 8 majority-clocked cycles, keystream XORed MSB first
// S_HOLD       | out_valid high until out_ready
module a51_stream_decryptor #(
  parameter int MIX_CYCLES = 100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [63:0] key_i,
  input  logic [21:0] frame_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o
`ifdef A51_KEYSTREAM_TAP_EN
  ,
  output logic        ks_bit_o,
  output logic        ks_valid_o
`endif
);

  localparam int CNT_W = $clog2((MIX_CYCLES > 64) ? MIX_CYCLES : 64);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_KEY, S_LOAD_FRAME, S_MIX, S_WAIT, S_GEN, S_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [18:0]       x_q, x_d, x_sh, x_maj;
  logic [21:0]       y_q, y_d, y_sh, y_maj;
  logic [22:0]       z_q, z_d, z_sh, z_maj;
  logic [85:0]       sh_q, sh_d;
  logic [7:0]        byte_q, byte_d;
  logic              inj, maj, ks;

  // Key then frame bits leave the LSB of one shift register, so both load phases share the injector.
  assign inj  = (state_q == S_LOAD_KEY || state_q == S_LOAD_FRAME) ? sh_q[0] : 1'b0;
  assign x_sh = {x_q[17:0], x_q[18] ^ x_q[17] ^ x_q[16] ^ x_q[13] ^ inj};
  assign y_sh = {y_q[20:0], y_q[21] ^ y_q[20] ^ inj};
  assign z_sh = {z_q[21:0], z_q[22] ^ z_q[21] ^ z_q[20] ^ z_q[7] ^ inj};

  assign maj   = (x_q[8] & y_q[10]) | (x_q[8] & z_q[10]) | (y_q[10] & z_q[10]);
  assign x_maj = (x_q[8]  == maj) ? x_sh : x_q;
  assign y_maj = (y_q[10] == maj) ? y_sh : y_q;
  assign z_maj = (z_q[10] == maj) ? z_sh : z_q;
  assign ks    = x_maj[18] ^ y_maj[21] ^ z_maj[22];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    sh_d    = sh_q;
    byte_d  = byte_q;
    unique case (state_q)
      S_IDLE: ;
      S_LOAD_KEY, S_LOAD_FRAME: begin
        x_d  = x_sh;
        y_d  = y_sh;
        z_d  = z_sh;
        sh_d = sh_q >> 1;
        if (cnt_q == '0) begin
          state_d = (state_q == S_LOAD_KEY) ? S_LOAD_FRAME : S_MIX;
          cnt_d   = (state_q == S_LOAD_KEY) ? CNT_W'(21) : CNT_W'(MIX_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_MIX, S_GEN: begin
        x_d = x_maj;
        y_d = y_maj;
        z_d = z_maj;
        // Rotate left with the keystream folded into the outgoing MSB: bit k lands on bit 7-k.
        if (state_q == S_GEN) byte_d = {byte_q[6:0], byte_q[7] ^ ks};
        if (cnt_q == '0) state_d = (state_q == S_MIX) ? S_WAIT : S_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_WAIT: begin
        if (in_valid_i) begin
          state_d = S_GEN;
          byte_d  = in_data_i;
          cnt_d   = CNT_W'(7);
        end
      end
      S_HOLD: begin
        if (out_ready_i) state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
    if (start_i) begin
      state_d = S_LOAD_KEY;
      cnt_d   = CNT_W'(63);
      x_d     = '0;
      y_d     = '0;
      z_d     = '0;
      sh_d    = {frame_i, key_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      sh_q   <= '0;
      byte_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      sh_q   <= sh_d;
      byte_q <= byte_d;
    end
  end

  assign in_ready_o  = (state_q == S_WAIT);
  assign out_valid_o = (state_q == S_HOLD);
  assign out_data_o  = byte_q;
  assign busy_o      = (state_q != S_IDLE);

`ifdef A51_KEYSTREAM_TAP_EN
  assign ks_bit_o   = ks;
  assign ks_valid_o = (state_q == S_GEN);
`endif

endmodule

// File: tb/tb_a51_stream_decryptor.sv
// Self-checking bench for a51_stream_decryptor: reference vectors plus random sessions
// checked against a bit-array A5/1 model.
module tb_a51_stream_decryptor;

  localparam logic [63:0] STD_KEY   = 64'hEFCDAB8967452312;
  localparam logic [21:0] STD_FRAME = 22'h134;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [63:0] key_i = '0;
  logic [21:0] frame_i = '0;
  logic [7:0]  in_data_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic        busy_o;
`ifdef A51_KEYSTREAM_TAP_EN
  logic        ks_bit_o;
  logic        ks_valid_o;
`endif

  a51_stream_decryptor dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .key_i       (key_i),
    .frame_i     (frame_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
`ifdef A51_KEYSTREAM_TAP_EN
    ,
    .ks_bit_o    (ks_bit_o),
    .ks_valid_o  (ks_valid_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: three registers as plain bit arrays, generic tap lists.
  bit [22:0] mr [3];
  int lens [3]    = '{19, 22, 23};
  int taps [3][4] = '{'{18, 17, 16, 13}, '{21, 20, -1, -1}, '{22, 21, 20, 7}};
  int clkb [3]    = '{8, 10, 10};

  task automatic m_shift(input int r, input bit inj);
    bit fb = inj;
    for (int t = 0; t < 4; t++) if (taps[r][t] >= 0) fb ^= mr[r][taps[r][t]];
    for (int b = lens[r] - 1; b > 0; b--) mr[r][b] = mr[r][b-1];
    mr[r][0] = fb;
  endtask

  task automatic m_clock_maj();
    int ones = 0;
    bit cb [3];
    for (int r = 0; r < 3; r++) begin cb[r] = mr[r][clkb[r]]; ones += int'(cb[r]); end
    for (int r = 0; r < 3; r++) if (cb[r] == (ones >= 2)) m_shift(r, 1'b0);
  endtask

  task automatic m_setup(input logic [63:0] k, input logic [21:0] f);
    for (int r = 0; r < 3; r++) mr[r] = '0;
    for (int i = 0; i < 64; i++) for (int r = 0; r < 3; r++) m_shift(r, k[i]);
    for (int i = 0; i < 22; i++) for (int r = 0; r < 3; r++) m_shift(r, f[i]);
    for (int i = 0; i < 100; i++) m_clock_maj();
  endtask

  function automatic logic [7:0] dummy_zero();
    return 8'h00;
  endfunction

  task automatic m_byte(input logic [7:0] din, output logic [7:0] dout);
    dout = din;
    for (int k = 0; k < 8; k++) begin
      m_clock_maj();
      dout[7-k] = dout[7-k] ^ (mr[0][18] ^ mr[1][21] ^ mr[2][22]);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Pulses start and returns edges from the start edge until in_ready rises; key/frame are scrambled afterwards.
  task automatic start_session(input logic [63:0] k, input logic [21:0] f, output int lat);
    key_i = k; frame_i = f; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    key_i = {$urandom, $urandom};
    frame_i = 22'($urandom);
    chk("busy_after_start", busy_o, 1'b1);
    lat = 0;
    while (!in_ready_o && lat < 400) begin tick(); lat++; end
  endtask

  task automatic send_byte(input logic [7:0] din, input int stall, input string tag, output logic [7:0] dout);
    int lat = 0;
    logic [7:0] held;
    while (!in_ready_o && lat < 50) begin tick(); lat++; end
    in_data_i = din; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0; in_data_i = 8'($urandom);
    lat = 0;
    while (!out_valid_o && lat < 30) begin tick(); lat++; end
    chk({tag, "_latency"}, lat, 8);
    held = out_data_o;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (out_data_o !== held || in_ready_o !== 1'b0 || out_valid_o !== 1'b1)
        chk({tag, "_stall_stable"}, {out_valid_o, in_ready_o, out_data_o}, {1'b1, 1'b0, held});
    end
    dout = out_data_o;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0] got, exp;
    logic [63:0] rk;
    logic [21:0] rf;
    bit seen;

    #2;
    chk("reset_outputs", {in_ready_o, out_valid_o, out_data_o, busy_o}, 11'd0);
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    chk("idle_after_reset", {in_ready_o, out_valid_o, out_data_o, busy_o}, 11'd0);

    // Standard vector with zero bytes.
    start_session(STD_KEY, STD_FRAME, lat);
    chk("setup_latency", lat, 186);
    m_setup(STD_KEY, STD_FRAME);
    send_byte(8'h00, 0, "std0", got); chk("std_byte0", got, 8'h53); m_byte(8'h00, exp);
    send_byte(8'h00, 0, "std1", got); chk("std_byte1", got, 8'h4E); m_byte(8'h00, exp);
    send_byte(8'h00, 0, "std2", got); chk("std_byte2", got, 8'hAA); m_byte(8'h00, exp);

    // 0xFF bytes, keystream continues across bytes.
    start_session(STD_KEY, STD_FRAME, lat);
    send_byte(8'hFF, 0, "ff0", got); chk("ff_byte0", got, 8'hAC);
    send_byte(8'hFF, 0, "ff1", got); chk("ff_byte1", got, 8'hB1);

    // Backpressure: 20 stalled cycles in HOLD.
    start_session(STD_KEY, STD_FRAME, lat);
    send_byte(8'h00, 20, "bp0", got); chk("bp_byte0", got, 8'h53);
    send_byte(8'h00, 0, "bp1", got);  chk("bp_byte1", got, 8'h4E);

    // Abort during GEN.
    start_session(STD_KEY, STD_FRAME, lat);
    in_data_i = 8'h00; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    repeat (3) tick();
    key_i = STD_KEY; frame_i = STD_FRAME; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    seen = 1'b0; lat = 0;
    while (!in_ready_o && lat < 400) begin
      if (out_valid_o) seen = 1'b1;
      tick(); lat++;
    end
    chk("abort_no_valid", seen, 1'b0);
    chk("abort_setup_latency", lat, 186);
    send_byte(8'h00, 0, "abort", got); chk("abort_byte0", got, 8'h53);

    // Async reset mid-MIX.
    start_session(STD_KEY, STD_FRAME, lat);
    send_byte(8'h00, 0, "pre_rst", got);
    key_i = STD_KEY; frame_i = STD_FRAME; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (120) tick();
    #2 rst_ni = 1'b0;
    #1 chk("async_reset_outputs", {in_ready_o, out_valid_o, out_data_o, busy_o}, 11'd0);
    tick();
    rst_ni = 1'b1;
    repeat (5) tick();
    chk("idle_after_reset_release", busy_o, 1'b0);
    start_session(STD_KEY, STD_FRAME, lat);
    chk("post_reset_latency", lat, 186);
    send_byte(8'h00, 0, "post_rst", got); chk("post_reset_byte0", got, 8'h53);

    // Random sessions against the model.
    for (int s = 0; s < 3; s++) begin
      rk = {$urandom, $urandom};
      rf = 22'($urandom);
      start_session(rk, rf, lat);
      chk("rand_setup_latency", lat, 186);
      m_setup(rk, rf);
      for (int b = 0; b < 6; b++) begin
        logic [7:0] din;
        din = 8'($urandom);
        send_byte(din, int'($urandom_range(0, 3)), "rand", got);
        m_byte(din, exp);
        chk("rand_byte", got, exp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
